// File: rtl/kyber_butterfly_reduce.sv
// Kyber NTT butterfly back end: forms a+t / a-t from the fqmul product and
// Barrett-reduces both to centred representatives in a 2-stage valid/ready pipe.
module kyber_butterfly_reduce #(
  parameter int TAG_W     = 8,
  parameter int KYBER_Q   = 3329,
  parameter int BARRETT_V = 20159
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_a,
  input  logic signed [15:0]      in_t,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_sum,
  output logic signed [15:0]      out_diff,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  localparam logic signed [31:0] ROUND_C = 32'sd33554432;

  // Quotient estimate rounds x*V/2^26; the final subtraction is taken modulo 2^16.
  function automatic logic signed [15:0] barrett(input logic signed [16:0] x);
    logic signed [31:0] xe;
    xe = $signed({{15{x[16]}}, x});
    return 16'(xe - KYBER_Q * ((BARRETT_V * xe + ROUND_C) >>> 26));
  endfunction

  logic                     s1_valid_q, s1_valid_d;
  logic signed [16:0]       s1_sum_q, s1_sum_d;
  logic signed [16:0]       s1_diff_q, s1_diff_d;
  logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [15:0]       s2_sum_q, s2_sum_d;
  logic signed [15:0]       s2_diff_q, s2_diff_d;
  logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;
  logic                     s1_adv_s, s2_adv_s;
  logic signed [16:0]       a_ext_s, t_ext_s;

  // Advance conditions and next-state for both stages
  always_comb begin
    s2_adv_s   = !s2_valid_q || out_ready;
    s1_adv_s   = !s1_valid_q || s2_adv_s;
    a_ext_s    = $signed({in_a[15], in_a});
    t_ext_s    = $signed({in_t[15], in_t});
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_diff_d  = s1_diff_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_diff_d  = s2_diff_q;
    s2_tag_d   = s2_tag_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = a_ext_s + t_ext_s;
        s1_diff_d = a_ext_s - t_ext_s;
        s1_tag_d  = in_tag;
      end else begin
        s1_tag_d  = s1_tag_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = barrett(s1_sum_q);
      s2_diff_d  = barrett(s1_diff_q);
      s2_tag_d   = s1_tag_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= 17'sd0;
      s1_diff_q  <= 17'sd0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= 16'sd0;
      s2_diff_q  <= 16'sd0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_diff_q  <= s1_diff_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_diff_q  <= s2_diff_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_diff  = s2_diff_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_kyber_butterfly_reduce.sv
// Scoreboard bench for kyber_butterfly_reduce: driver pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_kyber_butterfly_reduce;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [15:0] in_a = 16'sd0;
  logic signed [15:0] in_t = 16'sd0;
  logic [7:0]        in_tag = 8'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [15:0] out_sum;
  logic signed [15:0] out_diff;
  logic [7:0]        out_tag;
  logic              busy;

  typedef struct {
    int sum;
    int diff;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;
  bit   rand_ready = 1'b0;
  bit   range_chk = 1'b0;
  bit   hold_prev = 1'b0;
  int   hold_sum, hold_diff, hold_tag;

  kyber_butterfly_reduce #(.TAG_W(8), .KYBER_Q(3329), .BARRETT_V(20159)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_t(in_t), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_diff(out_diff),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Centred residue in [-1664, 1664], computed directly from the modulus.
  function automatic int ref_red(input int x);
    int r;
    r = x % 3329;
    if (r > 1664) r -= 3329;
    if (r < -1664) r += 3329;
    return r;
  endfunction

  task automatic send(input int a, input int t, input int tag, input int es, input int ed);
    exp_t e;
    int   budget;
    in_valid = 1'b1;
    in_a = 16'(a);
    in_t = 16'(t);
    in_tag = 8'(tag);
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.sum = es; e.diff = ed; e.tag = tag;
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input int a, input int t, input int tag);
    send(a, t, tag, ref_red(a + t), ref_red(a - t));
  endtask

  // Monitor: compare each transfer against the scoreboard, check hold stability
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else if (out_valid && out_ready) begin
      hold_prev = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", int'(out_sum), e.sum);
        chk("out_diff", int'(out_diff), e.diff);
        chk("out_tag", int'(out_tag), e.tag);
        if (range_chk) begin
          chk("sum_range", int'(out_sum >= -16'sd1664 && out_sum <= 16'sd1664), 1);
          chk("diff_range", int'(out_diff >= -16'sd1664 && out_diff <= 16'sd1664), 1);
        end
      end
    end else if (out_valid) begin
      if (hold_prev) begin
        chk("stall_sum_stable", int'(out_sum), hold_sum);
        chk("stall_diff_stable", int'(out_diff), hold_diff);
        chk("stall_tag_stable", int'(out_tag), hold_tag);
      end
      hold_prev = 1'b1;
      hold_sum = int'(out_sum);
      hold_diff = int'(out_diff);
      hold_tag = int'(out_tag);
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Random downstream duty when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int budget;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_diff", int'(out_diff), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Basic latency and single-cycle valid
    send(100, 50, 8'h01, 150, 50);
    @(negedge clk);
    chk("lat_cycle1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("valid_one_cycle", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Wrap and centred boundary vectors
    send(3000, 3000, 2, -658, 0);
    send(-3000, 3000, 3, 0, 658);
    send(1664, 1, 4, -1664, 1663);
    send(-1664, -1, 5, 1664, -1663);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 8 pairs against a 5-cycle stall
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_m(i * 700 - 2500, 3328 - i * 811, i);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts_before_release", n_acc, 2);
        chk("bp_in_ready_low", int'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);

    // Reset mid-operation discards in-flight pairs
    out_ready = 1'b0;
    send(10, 20, 8'hA0, 30, -10);
    send(40, 50, 8'hA1, 90, -10);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_stale", int'(out_valid), 0);

    // Random regression with random valid/ready duty
    range_chk = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      int a, t;
      a = int'($urandom_range(0, 6656)) - 3328;
      t = int'($urandom_range(0, 6656)) - 3328;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      send_m(a, t, i & 255);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #1;
    chk("final_drain", exp_q.size(), 0);
    @(negedge clk);
    chk("final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
